// File: rtl/ristretto_pkg.sv
// ristretto_pkg
//   Shared types for the Ristretto core's memory-port arbiter.
//   arb_src_e : which requester issued a bus transaction (IF or LSU).
//   arb_id_t  : one in-flight transaction tag; squash marks a fetch whose
//               response must be dropped because the front end was flushed.
package ristretto_pkg;

    typedef enum logic {
        ARB_SRC_IF  = 1'b0,
        ARB_SRC_LSU = 1'b1
    } arb_src_e;

    typedef struct packed {
        arb_src_e src;
        logic     squash;
    } arb_id_t;

endpackage

// File: rtl/ristretto_arb_id_fifo.sv
// ristretto_arb_id_fifo
//   Ordered queue of in-flight transaction IDs. The bus returns responses in
//   issue order, so the head always names the issuer of the next rvalid.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         enqueue push_id_i (ignored when full)
//   push_id_i      ID of the transaction granted this cycle
//   pop_i          dequeue the head (ignored when empty)
//   squash_if_i    mark every IF entry, including one pushed now, as squashed
//   head_o         registered head entry
//   count_o        number of entries held
//   empty_o        count_o == 0
module ristretto_arb_id_fifo
    import ristretto_pkg::*;
#(
    parameter  int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  arb_id_t         push_id_i,
    input  logic            pop_i,
    input  logic            squash_if_i,
    output arb_id_t         head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    arb_id_t         entries_q [Depth];
    arb_id_t         entries_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && (cnt_q != CntW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = cnt_q;

    // NOTE: every signal written here gets a default first, otherwise the
    // paths that skip an assignment infer a latch.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;

        if (squash_if_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                if (entries_q[i].src == ARB_SRC_IF) begin
                    entries_d[i].squash = 1'b1;
                end
            end
        end

        if (do_push) begin
            entries_d[wr_ptr_q] = push_id_i;
            if (squash_if_i && push_id_i.src == ARB_SRC_IF) begin
                entries_d[wr_ptr_q].squash = 1'b1;
            end
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: the ID storage is reset too; it is only a few bits, and a
            // stale squash/src bit must never route a response after reset.
            for (int i = 0; i < int'(Depth); i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/ristretto_mem_port_arbiter.sv
// ristretto_mem_port_arbiter
//   Shares the single OBI-style memory port between instruction fetch (read
//   only) and the load/store unit, and routes in-order responses back to the
//   issuer via an ID queue. Fetch responses in flight at a front-end flush
//   are discarded.
// Configuration macro:
//   RISTRETTO_ARB_STARVE_GUARD_EN  force a fetch after StarveLimit consecutive
//                                  LSU grants while a fetch waits; without it
//                                  the LSU has strict priority.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   if_req_i/if_addr_i/if_gnt_o       fetch request channel
//   if_rvalid_o/if_rdata_o/if_err_o   fetch response channel
//   if_flush_i                        one-cycle front-end flush
//   lsu_req_i/we/be/addr/wdata, lsu_gnt_o   LSU request channel
//   lsu_rvalid_o/lsu_rdata_o/lsu_err_o      LSU response channel
//   mem_req_o/we/be/addr/wdata, mem_gnt_i   bus request channel
//   mem_rvalid_i/mem_rdata_i/mem_err_i      bus response channel
//   arb_busy_o                        at least one transaction outstanding
module ristretto_mem_port_arbiter
    import ristretto_pkg::*;
#(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned StarveLimit    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   if_req_i,
    input  logic [AddrWidth-1:0]   if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [DataWidth-1:0]   if_rdata_o,
    output logic                   if_err_o,
    input  logic                   if_flush_i,
    input  logic                   lsu_req_i,
    input  logic                   lsu_we_i,
    input  logic [DataWidth/8-1:0] lsu_be_i,
    input  logic [AddrWidth-1:0]   lsu_addr_i,
    input  logic [DataWidth-1:0]   lsu_wdata_i,
    output logic                   lsu_gnt_o,
    output logic                   lsu_rvalid_o,
    output logic [DataWidth-1:0]   lsu_rdata_o,
    output logic                   lsu_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i,
    input  logic                   mem_err_i,
    output logic                   arb_busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    // Lock: a request presented but not granted is replayed unchanged from
    // these registers until the bus accepts it.
    logic                   lock_q, lock_d;
    arb_src_e               lock_src_q, lock_src_d;
    logic                   lock_sq_q, lock_sq_d;   // locked fetch was flushed
    logic                   hold_we_q, hold_we_d;
    logic [DataWidth/8-1:0] hold_be_q, hold_be_d;
    logic [AddrWidth-1:0]   hold_addr_q, hold_addr_d;
    logic [DataWidth-1:0]   hold_wdata_q, hold_wdata_d;

    arb_src_e               sel_src;
    logic                   sel_req, if_req_m, starve_trip, grant, sq_new;
    logic                   live_we;
    logic [DataWidth/8-1:0] live_be;
    logic [AddrWidth-1:0]   live_addr;
    logic [DataWidth-1:0]   live_wdata;
    arb_id_t                push_id, head;
    logic [CntW-1:0]        fifo_cnt;
    logic                   fifo_empty, resp_v;

    always_comb begin
        if_req_m = if_req_i & ~if_flush_i;
        sel_src  = ARB_SRC_IF;
        sel_req  = 1'b0;
        if (lock_q) begin
            sel_src = lock_src_q;
            sel_req = 1'b1;
        end else if (starve_trip && if_req_m) begin
            sel_src = ARB_SRC_IF;
            sel_req = 1'b1;
        end else if (lsu_req_i) begin
            sel_src = ARB_SRC_LSU;
            sel_req = 1'b1;
        end else begin
            sel_src = ARB_SRC_IF;
            sel_req = if_req_m;
        end
    end

    always_comb begin
        if (sel_src == ARB_SRC_IF) begin
            live_we    = 1'b0;
            live_be    = '1;
            live_addr  = if_addr_i;
            live_wdata = '0;
        end else begin
            live_we    = lsu_we_i;
            live_be    = lsu_be_i;
            live_addr  = lsu_addr_i;
            live_wdata = lsu_wdata_i;
        end
    end

    assign mem_req_o   = sel_req && (fifo_cnt < CntW'(MaxOutstanding));
    assign mem_we_o    = mem_req_o && (lock_q ? hold_we_q : live_we);
    assign mem_be_o    = !mem_req_o ? '0 : (lock_q ? hold_be_q    : live_be);
    assign mem_addr_o  = !mem_req_o ? '0 : (lock_q ? hold_addr_q  : live_addr);
    assign mem_wdata_o = !mem_req_o ? '0 : (lock_q ? hold_wdata_q : live_wdata);

    // A fetch granted during a flush, or locked across one, still completes
    // on the bus but is hidden from the front end.
    assign grant     = mem_req_o && mem_gnt_i;
    assign sq_new    = (sel_src == ARB_SRC_IF) && (if_flush_i || (lock_q && lock_sq_q));
    assign if_gnt_o  = grant && (sel_src == ARB_SRC_IF) && !sq_new;
    assign lsu_gnt_o = grant && (sel_src == ARB_SRC_LSU);
    assign push_id   = '{src: sel_src, squash: sq_new};

    always_comb begin
        lock_d       = lock_q;
        lock_src_d   = lock_src_q;
        lock_sq_d    = lock_sq_q;
        hold_we_d    = hold_we_q;
        hold_be_d    = hold_be_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        if (mem_req_o && !mem_gnt_i) begin
            lock_d = 1'b1;
            if (!lock_q) begin
                lock_src_d   = sel_src;
                lock_sq_d    = 1'b0;
                hold_we_d    = live_we;
                hold_be_d    = live_be;
                hold_addr_d  = live_addr;
                hold_wdata_d = live_wdata;
            end
            if (if_flush_i && sel_src == ARB_SRC_IF) begin
                lock_sq_d = 1'b1;
            end
        end else if (grant) begin
            lock_d    = 1'b0;
            lock_sq_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_src_q   <= ARB_SRC_IF;
            lock_sq_q    <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_be_q    <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            lock_q       <= lock_d;
            lock_src_q   <= lock_src_d;
            lock_sq_q    <= lock_sq_d;
            hold_we_q    <= hold_we_d;
            hold_be_q    <= hold_be_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
        end
    end

`ifdef RISTRETTO_ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);
    logic [StarveW-1:0] starve_q, starve_d;

    // Counts LSU grants that overtook a waiting fetch; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || (grant && sel_src == ARB_SRC_IF)) begin
            starve_d = '0;
        end else if (grant && sel_src == ARB_SRC_LSU && starve_q < StarveW'(StarveLimit)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign starve_trip = (starve_q >= StarveW'(StarveLimit));
`else
    assign starve_trip = 1'b0;
`endif

    ristretto_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (grant),
        .push_id_i   (push_id),
        .pop_i       (mem_rvalid_i),
        .squash_if_i (if_flush_i),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty)
    );

    // A response with nothing outstanding (e.g. stale after reset) is dropped.
    assign resp_v       = mem_rvalid_i && !fifo_empty;
    assign if_rvalid_o  = resp_v && (head.src == ARB_SRC_IF) && !head.squash;
    assign lsu_rvalid_o = resp_v && (head.src == ARB_SRC_LSU);
    assign if_rdata_o   = if_rvalid_o  ? mem_rdata_i : '0;
    assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
    assign if_err_o     = if_rvalid_o  && mem_err_i;
    assign lsu_err_o    = lsu_rvalid_o && mem_err_i;
    assign arb_busy_o   = !fifo_empty;

    a_param_range: assert property (@(posedge clk_i)
        (MaxOutstanding >= 1) && (MaxOutstanding <= 4) && (StarveLimit >= 1))
        else $error("arbiter parameters out of range");

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_rvalid_i |-> !fifo_empty)
        else $error("rvalid with no outstanding transaction");

endmodule

// File: doc/ristretto_mem_port_arbiter.md
# ristretto_mem_port_arbiter

Shares the core's single OBI-style memory port between the instruction fetch stage (read-only) and the load/store unit (read/write), and routes responses back to their issuer. Sits between the IF/EXE stages and the bus. Tracks in-flight transactions in a small ordered ID queue. Discards fetch responses that were already in flight when the pipeline control unit flushes the front end.

## Interface
Parameters:
- DataWidth, 32: width of wdata/rdata.
- AddrWidth, 32: width of addresses.
- MaxOutstanding, 2: maximum number of granted transactions awaiting rvalid (1..4).
- StarveLimit, 4: number of consecutive LSU grants while a fetch waits before the fetch is forced; only used with the starvation guard.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  AddrWidth  fetch address.
- if_gnt_o  out  1  fetch request accepted.
- if_rvalid_o  out  1  fetch read data valid.
- if_rdata_o  out  DataWidth  fetch read data.
- if_err_o  out  1  fetch bus error, qualified by if_rvalid_o.
- if_flush_i  in  1  one-cycle front-end flush from the pipeline control unit.
- lsu_req_i  in  1  LSU request.
- lsu_we_i  in  1  LSU write enable.
- lsu_be_i  in  DataWidth/8  byte enables.
- lsu_addr_i  in  AddrWidth  LSU address.
- lsu_wdata_i  in  DataWidth  write data.
- lsu_gnt_o  out  1  LSU request accepted.
- lsu_rvalid_o  out  1  LSU response valid; also asserted for writes.
- lsu_rdata_o  out  DataWidth  LSU read data.
- lsu_err_o  out  1  LSU bus error, qualified by lsu_rvalid_o.
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  1/1/DataWidth/8/AddrWidth/DataWidth  bus request.
- mem_gnt_i / mem_rvalid_i / mem_rdata_i / mem_err_i  in  1/1/DataWidth/1  bus response.
- arb_busy_o  out  1  at least one transaction outstanding.

## Operation
- Source select:
  - If the lock is set, the locked source is selected.
  - Otherwise, if the starvation guard has tripped and if_req_i is high, IF is selected.
  - Otherwise LSU has priority when lsu_req_i is high, else IF.
- mem_req_o = (selected request) & (count < MaxOutstanding). Bus fields are muxed from the selected source. For IF requests: we=0 and be all-ones.
- Lock: set when mem_req_o=1 and mem_gnt_i=0, holding the source. Cleared on grant. This keeps the request stable until it is accepted.
- Grant: src_gnt = mem_req_o & mem_gnt_i & (source selected). The ID queue pushes {source, squash}.
- Response: on mem_rvalid_i, pop the head.
  - Assert rvalid/err toward the head's source, with rdata passed through.
  - A squashed IF head is popped with no if_rvalid_o.
- Flush (if_flush_i=1):
  - Set the squash bit on every IF entry in the queue, including an entry pushed in the same cycle.
  - if_req_i is masked that cycle unless IF already holds the lock.
  - If an IF request is locked: it completes on the bus, if_gnt_o is suppressed, and the entry is pushed squashed.
- Same-cycle push and pop is legal; count is unchanged.
- Count saturation: the queue is full when count == MaxOutstanding. Popping with an empty queue (rvalid with nothing outstanding) is ignored, and the assertion fires.
- Reset (any time, including mid-transaction): count=0, queue cleared, lock cleared, starvation counter=0. All outputs are 0 until the next request. In-flight bus responses after reset are ignored.

## Timing
- Request path is combinational, req → mem_req_o. No added latency.
- Grant is combinational: gnt_i → if/lsu_gnt_o.
- Response path is combinational: rvalid_i → if/lsu_rvalid_o, routed using the registered queue head.
- Lock, queue, count and starvation counter update on the rising edge after the event.
- Throughput: one grant per cycle when gnt_i is held high, bounded by MaxOutstanding.

## Configuration
- RISTRETTO_ARB_STARVE_GUARD_EN defined:
  - A counter increments on each LSU grant while if_req_i=1.
  - It clears on an IF grant or when if_req_i=0.
  - When count ≥ StarveLimit, the next unlocked arbitration selects IF.
- Not defined: strict LSU priority, with no counter logic.

## Structure
- Shared package ristretto_pkg holds:
  - typedef enum logic {ARB_SRC_IF, ARB_SRC_LSU} arb_src_e;
  - packed struct arb_id_t {arb_src_e src; logic squash;}.
- Sub-module ristretto_arb_id_fifo holds the ID queue. It is parameterised by depth, with push/pop/count and a squash-all-IF input.

## Test plan
- IF-only stream, gnt_i=1, rvalid one cycle later: 4 fetches are granted back-to-back, if_rvalid_o returns 4 times in order, and arb_busy_o falls after the last response.
- if_req_i and lsu_req_i both high from idle: LSU is granted first (lsu_gnt_o=1, if_gnt_o=0) and mem_we_o follows lsu_we_i.
- gnt_i held low 3 cycles with LSU request locked, then lsu_req_i dropped and if_req_i raised: mem_addr_o stays at the LSU address until the grant.
- MaxOutstanding=2, no rvalid: the third request sees mem_req_o=0. After one rvalid, the request issues the next cycle.
- Two IF reads outstanding, then if_flush_i for one cycle: both rvalids are swallowed (if_rvalid_o stays 0). A following LSU read's rvalid reaches lsu_rvalid_o.
- Guard enabled, StarveLimit=4, continuous LSU requests and pending fetch: 4 LSU grants, then 1 IF grant, then LSU resumes.
